// File: rtl/fetch_sequencer.sv
// Instruction fetch controller: owns the fetch PC, buffers ROM words with their PCs
// in a small FIFO and hands them to decode. Halt detection is enabled by FETCH_HALT_DETECT_EN.
module fetch_sequencer #(
  parameter int unsigned N      = 64,
  parameter int unsigned INSN_W = 32,
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DEPTH  = 2
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [INSN_W-1:0] imem_q,
  input  logic              redirect_valid,
  input  logic [N-1:0]      redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [INSN_W-1:0] out_insn,
  output logic [N-1:0]      out_pc,
  output logic              halted
);

  localparam int unsigned PTR_W = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [N-1:0]      fetch_pc;
  logic [N-1:0]      fetch_pc_nxt;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_nxt;
  logic [CNT_W-1:0]  remain;
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  head_nxt;
  logic [PTR_W-1:0]  tail;
  logic [PTR_W-1:0]  tail_nxt;
  logic [N-1:0]      mem_pc   [DEPTH];
  logic [INSN_W-1:0] mem_insn [DEPTH];
  logic              pop;
  logic              push;
  logic              fetch_en;
  logic              out_valid_nxt;
  logic [INSN_W-1:0] out_insn_nxt;
  logic [N-1:0]      out_pc_nxt;

  assign imem_addr = fetch_pc[ADDR_W+1:2];

`ifdef FETCH_HALT_DETECT_EN
  logic stop;
  logic stop_nxt;
  logic halted_nxt;
  logic is_halt;

  // CBZ with zero offset: a branch to itself, nothing useful lies beyond it
  assign is_halt  = (imem_q[31:24] == 8'hB4) && (imem_q[23:5] == 19'd0);
  assign fetch_en = !stop;

  always_comb begin
    stop_nxt   = stop;
    halted_nxt = halted;
    if (redirect_valid) begin
      stop_nxt   = 1'b0;
      halted_nxt = 1'b0;
    end else begin
      halted_nxt = stop && (count == '0);
      if (push && is_halt) stop_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stop   <= 1'b0;
      halted <= 1'b0;
    end else begin
      stop   <= stop_nxt;
      halted <= halted_nxt;
    end
  end
`else
  assign fetch_en = 1'b1;
  assign halted   = 1'b0;
`endif

  // FIFO bookkeeping and next head; the output registers mirror the post-edge head
  always_comb begin
    pop           = out_valid && out_ready;
    push          = !redirect_valid && fetch_en && ((count < CNT_W'(DEPTH)) || pop);
    remain        = pop ? count - CNT_W'(1) : count;
    head_nxt      = pop ? head + PTR_W'(1) : head;
    tail_nxt      = push ? tail + PTR_W'(1) : tail;
    count_nxt     = push ? remain + CNT_W'(1) : remain;
    fetch_pc_nxt  = push ? fetch_pc + N'(4) : fetch_pc;
    out_valid_nxt = (count_nxt != '0);
    out_insn_nxt  = out_insn;
    out_pc_nxt    = out_pc;
    if (redirect_valid) begin
      head_nxt      = '0;
      tail_nxt      = '0;
      count_nxt     = '0;
      out_valid_nxt = 1'b0;
      fetch_pc_nxt  = redirect_pc & ~N'(3);
    end else if (remain != '0) begin
      out_insn_nxt = mem_insn[head_nxt];
      out_pc_nxt   = mem_pc[head_nxt];
    end else if (push) begin
      out_insn_nxt = imem_q;
      out_pc_nxt   = fetch_pc;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc  <= '0;
      count     <= '0;
      head      <= '0;
      tail      <= '0;
      out_valid <= 1'b0;
      out_insn  <= '0;
      out_pc    <= '0;
    end else begin
      fetch_pc  <= fetch_pc_nxt;
      count     <= count_nxt;
      head      <= head_nxt;
      tail      <= tail_nxt;
      out_valid <= out_valid_nxt;
      out_insn  <= out_insn_nxt;
      out_pc    <= out_pc_nxt;
    end
  end

  // Entry storage needs no reset: count gates every read
  always_ff @(posedge clk) begin
    if (push) begin
      mem_pc[tail]   <= fetch_pc;
      mem_insn[tail] <= imem_q;
    end
  end

endmodule
